// File: rtl/mold_pack_if.sv
// mold_pack_if: descriptor, message and payload stream signals of the
// MoldUDP64 transmit packer, plus the packer's state for observation.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. A valid that has been raised stays high with stable payload
// until that edge. The packer's readies are combinational and drop whenever
// its own output beat is stalled (valid_o & ~ready_i).
interface mold_pack_if #(
  parameter int AXI_DATA_W = 64,
  parameter int AXI_KEEP_W = AXI_DATA_W / 8,
  parameter int LEN_W      = 16,
  parameter int SID_W      = 80,
  parameter int SEQ_W      = 64,
  parameter int CNT_W      = 16
);
  logic                  pkt_valid_i;
  logic                  pkt_ready_o;
  logic [SID_W-1:0]      pkt_sid_i;
  logic [SEQ_W-1:0]      pkt_seq_i;
  logic [CNT_W-1:0]      pkt_cnt_i;
  logic                  msg_valid_i;
  logic                  msg_ready_o;
  logic [LEN_W-1:0]      msg_len_i;
  logic [AXI_DATA_W-1:0] msg_data_i;
  logic                  valid_o;
  logic                  ready_i;
  logic [AXI_DATA_W-1:0] data_o;
  logic [AXI_KEEP_W-1:0] keep_o;
  logic                  last_o;
  logic [6:0]            state_o;

  // Packer side.
  modport slave (
    input  pkt_valid_i, pkt_sid_i, pkt_seq_i, pkt_cnt_i,
    input  msg_valid_i, msg_len_i, msg_data_i, ready_i,
    output pkt_ready_o, msg_ready_o, valid_o, data_o, keep_o, last_o, state_o
  );

  // Source of descriptors/messages and sink of the payload.
  modport master (
    output pkt_valid_i, pkt_sid_i, pkt_seq_i, pkt_cnt_i,
    output msg_valid_i, msg_len_i, msg_data_i, ready_i,
    input  pkt_ready_o, msg_ready_o, valid_o, data_o, keep_o, last_o, state_o
  );
endinterface

// File: rtl/mold_pack.sv
// mold_pack: packs a MoldUDP64 header (session, sequence, count) and a
// stream of length-prefixed messages into a byte-packed 64-bit stream.
// Bytes are collected in a 15-byte buffer; whenever 8 or more are held a full
// beat leaves, and the packet's final insertion closes it with last_o.
module mold_pack #(
  parameter int AXI_DATA_W = 64,
  parameter int AXI_KEEP_W = AXI_DATA_W / 8,
  parameter int LEN_W      = 16,
  parameter int SID_W      = 80,
  parameter int SEQ_W      = 64,
  parameter int CNT_W      = 16
) (
  input logic       clk,
  input logic       nreset,
  mold_pack_if.slave bus
);
  localparam int BUF_W = 2 * AXI_DATA_W - 8;

  typedef enum logic [6:0] {
    S_IDLE  = 7'b0000001,
    S_HDR0  = 7'b0000010,
    S_HDR1  = 7'b0000100,
    S_HDR2  = 7'b0001000,
    S_LEN   = 7'b0010000,
    S_DATA  = 7'b0100000,
    S_FLUSH = 7'b1000000
  } state_t;

  state_t                state_q, state_d;
  logic [SID_W-1:0]      sid_q, sid_d;
  logic [SEQ_W-1:0]      seq_q, seq_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [CNT_W-1:0]      left_q, left_d;
  logic [LEN_W-1:0]      rem_q, rem_d;
  logic [BUF_W-1:0]      buf_q, buf_d;
  logic [3:0]            bcnt_q, bcnt_d;
  logic                  valid_q, valid_d;
  logic [AXI_DATA_W-1:0] data_q, data_d;
  logic [AXI_KEEP_W-1:0] keep_q, keep_d;
  logic                  last_q, last_d;

  logic                  adv;
  logic [AXI_DATA_W-1:0] ins_data;
  logic [AXI_DATA_W-1:0] ins_mask;
  logic [3:0]            ins;
  logic                  pkt_end;
  logic [BUF_W-1:0]      merged;
  logic [4:0]            total;
  logic [8:0]            keep_w;

  // Everything moves only when the output register can accept a new beat.
  assign adv = ~valid_q | bus.ready_i;

  assign bus.pkt_ready_o = (state_q == S_IDLE) & adv;
  assign bus.msg_ready_o = (state_q == S_DATA) & adv;
  assign bus.valid_o     = valid_q;
  assign bus.data_o      = data_q;
  assign bus.keep_o      = keep_q;
  assign bus.last_o      = last_q;
  assign bus.state_o     = state_q;

  // Next state, bytes to insert this cycle, and buffer/beat assembly.
  always_comb begin
    state_d  = state_q;
    sid_d    = sid_q;
    seq_d    = seq_q;
    cnt_d    = cnt_q;
    left_d   = left_q;
    rem_d    = rem_q;
    buf_d    = buf_q;
    bcnt_d   = bcnt_q;
    valid_d  = valid_q;
    data_d   = data_q;
    keep_d   = keep_q;
    last_d   = last_q;
    ins      = 4'd0;
    ins_data = '0;
    ins_mask = '0;
    pkt_end  = 1'b0;
    merged   = '0;
    total    = '0;
    keep_w   = '0;

    unique case (state_q)
      S_IDLE: begin
        if (adv && bus.pkt_valid_i) begin
          sid_d   = bus.pkt_sid_i;
          seq_d   = bus.pkt_seq_i;
          cnt_d   = bus.pkt_cnt_i;
          left_d  = (bus.pkt_cnt_i == '1) ? '0 : bus.pkt_cnt_i;
          state_d = S_HDR0;
        end
      end
      S_HDR0: begin
        if (adv) begin
          ins = 4'd8;
          for (int k = 0; k < 8; k++) ins_data[8*k +: 8] = sid_q[SID_W-1-8*k -: 8];
          state_d = S_HDR1;
        end
      end
      S_HDR1: begin
        if (adv) begin
          ins = 4'd8;
          ins_data[15:0] = {sid_q[7:0], sid_q[15:8]};
          for (int k = 0; k < 6; k++) ins_data[16+8*k +: 8] = seq_q[SEQ_W-1-8*k -: 8];
          state_d = S_HDR2;
        end
      end
      S_HDR2: begin
        if (adv) begin
          ins = 4'd4;
          ins_data[31:0] = {cnt_q[7:0], cnt_q[15:8], seq_q[7:0], seq_q[15:8]};
          if (left_q != '0) state_d = S_LEN;
          else              pkt_end = 1'b1;
        end
      end
      S_LEN: begin
        // Length prefix is taken without consuming the message stream.
        if (adv && bus.msg_valid_i) begin
          ins = 4'd2;
          ins_data[15:0] = {bus.msg_len_i[7:0], bus.msg_len_i[15:8]};
          rem_d = bus.msg_len_i;
          if (bus.msg_len_i == '0) begin
            left_d = left_q - CNT_W'(1);
            if (left_q == CNT_W'(1)) pkt_end = 1'b1;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (adv && bus.msg_valid_i) begin
          ins_data = bus.msg_data_i;
          if (rem_q <= LEN_W'(8)) begin
            ins    = rem_q[3:0];
            left_d = left_q - CNT_W'(1);
            if (left_q == CNT_W'(1)) pkt_end = 1'b1;
            else                     state_d = S_LEN;
          end else begin
            ins   = 4'd8;
            rem_d = rem_q - LEN_W'(8);
          end
        end
      end
      S_FLUSH: begin
        if (adv) pkt_end = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    for (int k = 0; k < 8; k++) ins_mask[8*k +: 8] = (4'(k) < ins) ? 8'hFF : 8'h00;
    merged = buf_q | ({{(BUF_W-AXI_DATA_W){1'b0}}, ins_data & ins_mask} << {bcnt_q, 3'b000});
    total  = {1'b0, bcnt_q} + {1'b0, ins};
    keep_w = (9'd1 << total) - 9'd1;

    if (adv) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
      if (pkt_end && total <= 5'd8) begin
        valid_d = 1'b1;
        data_d  = merged[AXI_DATA_W-1:0];
        keep_d  = keep_w[AXI_KEEP_W-1:0];
        last_d  = 1'b1;
        buf_d   = '0;
        bcnt_d  = 4'd0;
        state_d = S_IDLE;
      end else if (total >= 5'd8) begin
        // A full beat leaves; an overfull final insertion finishes in FLUSH.
        valid_d = 1'b1;
        data_d  = merged[AXI_DATA_W-1:0];
        keep_d  = '1;
        buf_d   = merged >> AXI_DATA_W;
        bcnt_d  = 4'(total - 5'd8);
        if (pkt_end) state_d = S_FLUSH;
      end else begin
        buf_d  = merged;
        bcnt_d = total[3:0];
      end
    end
  end

  // State, buffer and registered output beat.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q <= S_IDLE;
      sid_q   <= '0;
      seq_q   <= '0;
      cnt_q   <= '0;
      left_q  <= '0;
      rem_q   <= '0;
      buf_q   <= '0;
      bcnt_q  <= 4'd0;
      valid_q <= 1'b0;
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sid_q   <= sid_d;
      seq_q   <= seq_d;
      cnt_q   <= cnt_d;
      left_q  <= left_d;
      rem_q   <= rem_d;
      buf_q   <= buf_d;
      bcnt_q  <= bcnt_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
      last_q  <= last_d;
    end
  end
endmodule

// File: tb/tb_mold_pack.sv
// tb_mold_pack: directed and random packets against a byte-stream model of
// the MoldUDP64 payload; beats are chopped from the model into exp_q.
module tb_mold_pack;
  logic clk = 1'b0;
  logic nreset;
  int   checks = 0;
  int   errors = 0;

  logic [72:0] exp_q[$];   // {last, keep, data}
  logic [72:0] got_q[$];
  logic [7:0]  body [0:511];
  int          lens [0:3];
  bit          mon_en = 1'b0;
  int          rdy_mode = 0;  // 0: always ready, 1: toggle, 2: random
  logic        stall_prev = 1'b0;
  logic [72:0] held = '0;

  mold_pack_if bus ();

  mold_pack dut (
    .clk    (clk),
    .nreset (nreset),
    .bus    (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    bus.ready_i = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (rdy_mode == 1)      bus.ready_i = ~bus.ready_i;
      else if (rdy_mode == 2) bus.ready_i = 1'($urandom_range(0, 1));
      else                    bus.ready_i = 1'b1;
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [72:0] obs, input logic [72:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] kmask(input logic [7:0] k);
    logic [63:0] m;
    m = '0;
    for (int j = 0; j < 8; j++) if (k[j]) m[8*j +: 8] = 8'hFF;
    return m;
  endfunction

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    logic [72:0] e;
    logic [72:0] cur;
    cur = {bus.last_o, bus.keep_o, bus.data_o};
    if (mon_en && nreset) begin
      if (stall_prev) begin
        chk("stall_valid_held", 73'(bus.valid_o), 73'(1));
        chk("stall_beat_held", cur, held);
      end
      if (bus.valid_o && !bus.ready_i) begin
        chk("stall_pkt_ready_low", 73'(bus.pkt_ready_o), 73'(0));
        chk("stall_msg_ready_low", 73'(bus.msg_ready_o), 73'(0));
      end
      if (bus.valid_o && bus.ready_i) begin
        got_q.push_back(cur);
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL extra_beat: observed %h expected no beat", cur);
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("beat_keep", 73'(cur[71:64]), 73'(e[71:64]));
          chk("beat_last", 73'(cur[72]), 73'(e[72]));
          chk("beat_data", 73'(cur[63:0] & kmask(e[71:64])), 73'(e[63:0]));
        end
      end
      stall_prev <= bus.valid_o && !bus.ready_i;
      held       <= cur;
    end else begin
      stall_prev <= 1'b0;
    end
  end

  // ---------------- model ----------------
  task automatic model_pkt(input logic [79:0] sid, input logic [63:0] seq,
                           input logic [15:0] cnt, input int n);
    logic [7:0]  bq[$];
    logic [15:0] l;
    logic [63:0] d;
    logic [7:0]  kp;
    int          off;
    for (int k = 0; k < 10; k++) bq.push_back(sid[79-8*k -: 8]);
    for (int k = 0; k < 8; k++)  bq.push_back(seq[63-8*k -: 8]);
    bq.push_back(cnt[15:8]);
    bq.push_back(cnt[7:0]);
    off = 0;
    for (int m = 0; m < n; m++) begin
      l = 16'(lens[m]);
      bq.push_back(l[15:8]);
      bq.push_back(l[7:0]);
      for (int j = 0; j < lens[m]; j++) bq.push_back(body[off+j]);
      off += lens[m];
    end
    for (int i = 0; i < bq.size(); i += 8) begin
      d  = '0;
      kp = '0;
      for (int j = 0; j < 8; j++) begin
        if (i + j < bq.size()) begin
          d[8*j +: 8] = bq[i+j];
          kp[j] = 1'b1;
        end
      end
      exp_q.push_back({(i + 8 >= bq.size()), kp, d});
    end
  endtask

  // ---------------- drivers ----------------
  task automatic send_pkt(input logic [79:0] sid, input logic [63:0] seq, input logic [15:0] cnt);
    bit ok;
    ok = 1'b0;
    bus.pkt_sid_i   = sid;
    bus.pkt_seq_i   = seq;
    bus.pkt_cnt_i   = cnt;
    bus.pkt_valid_i = 1'b1;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (bus.pkt_ready_o) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    bus.pkt_valid_i = 1'b0;
    chk("pkt_handshake", 73'(ok), 73'(1));
  endtask

  task automatic wait_msg_hs(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (bus.msg_ready_o) begin
        @(posedge clk); #1;
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic set_beat(input int off, input int len, input int b);
    for (int j = 0; j < 8; j++) begin
      if (8*b + j < len) bus.msg_data_i[8*j +: 8] = body[off + 8*b + j];
      else               bus.msg_data_i[8*j +: 8] = 8'($urandom_range(0, 255));
    end
  endtask

  task automatic send_msgs(input int n);
    int off;
    bit ok;
    off = 0;
    for (int m = 0; m < n; m++) begin
      bus.msg_valid_i = 1'b1;
      bus.msg_len_i   = 16'(lens[m]);
      for (int b = 0; b < (lens[m] + 7) / 8; b++) begin
        set_beat(off, lens[m], b);
        wait_msg_hs(ok);
        chk("msg_handshake", 73'(ok), 73'(1));
        if (!ok) begin
          bus.msg_valid_i = 1'b0;
          return;
        end
      end
      off += lens[m];
    end
    bus.msg_valid_i = 1'b0;
  endtask

  task automatic run_pkt(input logic [79:0] sid, input logic [63:0] seq,
                         input logic [15:0] cnt, input int n);
    got_q.delete();
    model_pkt(sid, seq, cnt, n);
    send_pkt(sid, seq, cnt);
    send_msgs(n);
    for (int k = 0; k < 300; k++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    repeat (3) @(posedge clk);
    #1;
    chk("drain_all_beats", 73'(exp_q.size()), 73'(0));
    exp_q.delete();
  endtask

  task automatic check_heartbeat(input string tag);
    chk({tag, "_beats"}, 73'(got_q.size()), 73'(3));
    if (got_q.size() == 3) begin
      chk({tag, "_beat0"}, got_q[0], {1'b0, 8'hFF, 64'h0807060504030201});
      chk({tag, "_beat1"}, got_q[1], {1'b0, 8'hFF, 64'h0000000000000A09});
      chk({tag, "_beat2_keep_last"}, 73'({got_q[2][72:64]}), 73'({1'b1, 8'h0F}));
      chk({tag, "_beat2_data"}, 73'(got_q[2][31:0]), 73'(32'h00000100));
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [79:0] hb_sid;
    logic [95:0] r;
    logic [63:0] rs;
    int          n;
    bit          ok;
    hb_sid          = 80'h0102030405060708090A;
    nreset          = 1'b0;
    bus.pkt_valid_i = 1'b0;
    bus.pkt_sid_i   = '0;
    bus.pkt_seq_i   = '0;
    bus.pkt_cnt_i   = '0;
    bus.msg_valid_i = 1'b0;
    bus.msg_len_i   = '0;
    bus.msg_data_i  = '0;
    for (int i = 0; i < 512; i++) body[i] = 8'($urandom_range(0, 255));

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 73'(bus.valid_o), 73'(0));
    chk("rst_data", 73'(bus.data_o), 73'(0));
    chk("rst_keep", 73'(bus.keep_o), 73'(0));
    chk("rst_last", 73'(bus.last_o), 73'(0));
    chk("rst_pkt_ready", 73'(bus.pkt_ready_o), 73'(1));
    chk("rst_msg_ready", 73'(bus.msg_ready_o), 73'(0));
    chk("rst_state_idle", 73'(bus.state_o), 73'(7'b0000001));
    @(posedge clk); #1;
    nreset = 1'b1;
    mon_en = 1'b1;
    @(posedge clk); #1;

    // Heartbeat, cnt 0.
    run_pkt(hb_sid, 64'd1, 16'd0, 0);
    check_heartbeat("hb");

    // cnt 0xFFFF also carries no bodies.
    run_pkt(hb_sid, 64'd1, 16'hFFFF, 0);
    chk("ffff_beats", 73'(got_q.size()), 73'(3));

    // One message, AA BB.
    lens[0] = 2; body[0] = 8'hAA; body[1] = 8'hBB;
    run_pkt(hb_sid, 64'd1, 16'd1, 1);
    chk("m2_beats", 73'(got_q.size()), 73'(3));
    if (got_q.size() == 3)
      chk("m2_beat2", got_q[2], {1'b1, 8'hFF, 64'hBBAA020001000100});

    // Two messages, 7 then 9, ready high and then toggling.
    for (int pass = 0; pass < 2; pass++) begin
      rdy_mode = pass;
      lens[0] = 7; lens[1] = 9;
      run_pkt(hb_sid, 64'h1122334455667788, 16'd2, 2);
      chk("m79_beats", 73'(got_q.size()), 73'(5));
      if (got_q.size() == 5) begin
        chk("m79_prefix2", 73'(got_q[3][55:40]), 73'(16'h0900));
        chk("m79_last_beat", 73'(got_q[4][72:64]), 73'({1'b1, 8'hFF}));
      end
    end
    rdy_mode = 0;

    // One message of 11 bytes ends through FLUSH.
    lens[0] = 11;
    run_pkt(hb_sid, 64'd5, 16'd1, 1);
    chk("m11_beats", 73'(got_q.size()), 73'(5));
    if (got_q.size() == 5)
      chk("m11_last_beat", 73'(got_q[4][72:64]), 73'({1'b1, 8'h01}));

    // Random packets under random backpressure.
    rdy_mode = 2;
    for (int p = 0; p < 6; p++) begin
      for (int i = 0; i < 512; i++) body[i] = 8'($urandom_range(0, 255));
      n = $urandom_range(1, 4);
      for (int m = 0; m < n; m++) lens[m] = $urandom_range(1, 30);
      r  = {$urandom, $urandom, $urandom};
      rs = {$urandom, $urandom};
      run_pkt(r[79:0], rs, 16'(n), n);
    end
    rdy_mode = 0;

    // Reset during DATA of a 3-message packet.
    mon_en = 1'b0;
    @(posedge clk); #1;
    lens[0] = 20; lens[1] = 20; lens[2] = 20;
    send_pkt(hb_sid, 64'd9, 16'd3);
    bus.msg_valid_i = 1'b1;
    bus.msg_len_i   = 16'd20;
    set_beat(0, 20, 0);
    wait_msg_hs(ok);
    chk("abort_hs0", 73'(ok), 73'(1));
    set_beat(0, 20, 1);
    wait_msg_hs(ok);
    chk("abort_hs1", 73'(ok), 73'(1));
    chk("abort_in_data", 73'(bus.state_o), 73'(7'b0100000));
    nreset = 1'b0;
    bus.msg_valid_i = 1'b0;
    @(posedge clk); #1;
    chk("abort_valid", 73'(bus.valid_o), 73'(0));
    chk("abort_last", 73'(bus.last_o), 73'(0));
    chk("abort_pkt_ready", 73'(bus.pkt_ready_o), 73'(1));
    chk("abort_msg_ready", 73'(bus.msg_ready_o), 73'(0));
    nreset = 1'b1;
    exp_q.delete();
    got_q.delete();
    mon_en = 1'b1;
    @(posedge clk); #1;
    run_pkt(hb_sid, 64'd1, 16'd0, 0);
    check_heartbeat("hb_after_abort");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mold_pack.md
# mold_pack

Transmit-side MoldUDP64 payload packer, the egress counterpart of the receive dispatcher. It accepts a packet descriptor (session, sequence number, message count) and then a stream of messages. It emits a byte-packed 64-bit AXI-stream payload: the 20-byte header followed by each message as a 2-byte big-endian length prefix plus body. Messages straddle beat boundaries with no padding, and the final beat carries `last_o`.

## Interface
- `AXI_DATA_W`, 64, payload and message data width.
- `AXI_KEEP_W`, `AXI_DATA_W/8`, byte lanes.
- `LEN_W`, 16, message length field width.
- `SID_W`, 80, session id width (10 bytes).
- `SEQ_W`, 64, sequence number width.
- `CNT_W`, 16, message count width.

Ports:
- `clk` in 1: clock. Single clock domain.
- `nreset` in 1: synchronous, active-low reset.
- `pkt_valid_i` in 1: packet descriptor valid.
- `pkt_ready_o` out 1: descriptor accepted. High only in IDLE.
- `pkt_sid_i` in `SID_W`: session id. Byte 0 is `[79:72]`.
- `pkt_seq_i` in `SEQ_W`: sequence number, big-endian on the wire.
- `pkt_cnt_i` in `CNT_W`: message count. Both 0 and 0xFFFF mean no message bodies follow.
- `msg_valid_i` in 1: message length or data valid.
- `msg_ready_o` out 1: message data beat consumed. Low in LEN.
- `msg_len_i` in `LEN_W`: message byte length, sampled in LEN.
- `msg_data_i` in `AXI_DATA_W`: message bytes. Byte 0 is `[7:0]`. Beats are full except the final one.
- `valid_o` out 1: output beat valid.
- `ready_i` in 1: downstream ready.
- `data_o` out `AXI_DATA_W`: payload. Byte 0 is `[7:0]`.
- `keep_o` out `AXI_KEEP_W`: contiguous from bit 0.
- `last_o` out 1: final beat of the payload.

## Operation
- States: IDLE, HDR0, HDR1, HDR2, LEN, DATA, FLUSH. One-hot.
- `adv = ~valid_o | ready_i`. The FSM, the byte buffer and both input readies move only when `adv` is high.
- Byte buffer: 15 bytes plus a 4-bit count `bcnt` (≤7 between cycles). Each advancing cycle inserts `ins` bytes (0..8) at lane `bcnt`.
  - If `bcnt+ins ≥ 8`: emit the low 8 bytes with keep 0xFF, shift the buffer down by 8, subtract 8 from `bcnt`.
  - Otherwise: no beat is emitted; `valid_o` drops once the prior beat is taken.
- State actions and transitions:
  - IDLE: on `pkt_valid_i`, latch sid, seq and cnt; `msg_left = cnt` (forced 0 if cnt is 0xFFFF); go to HDR0.
  - HDR0: insert sid bytes 0..7.
  - HDR1: insert sid bytes 8..9 and seq bytes 0..5.
  - HDR2: insert seq bytes 6..7 and cnt bytes 0..1 (4 bytes). Go to LEN if `msg_left≠0`, else end the packet.
  - LEN: wait for `msg_valid_i`, then insert `{len[15:8], len[7:0]}` (2 bytes) and set `rem = len`. Nothing is consumed.
    - If `len==0`: decrement `msg_left`; go to LEN, or end the packet when `msg_left` reaches 0.
    - Else go to DATA.
  - DATA: on `msg_valid_i & msg_ready_o`, insert `min(rem,8)` bytes and set `rem -= 8`. When `rem ≤ 8`, decrement `msg_left`; go to LEN, or end the packet when `msg_left` was 1.
- Packet end, on the final insertion:
  - If `bcnt+ins ≤ 8`: emit that beat with `last_o=1` and `keep_o = (1<<(bcnt+ins))-1`, then go to IDLE.
  - Otherwise: emit a full beat and go to FLUSH, which emits the remainder with `last_o=1` and returns to IDLE.
- Unused bytes of `msg_data_i` on the final beat of a message are ignored. `data_o` bytes above `keep_o` are don't-care.
- Length arithmetic is `LEN_W`-bit. A message length above 0xFFFF is out of scope.

## Timing
- Reset values: `valid_o`=0, `data_o`=0, `keep_o`=0, `last_o`=0, state IDLE, `pkt_ready_o`=1, `msg_ready_o`=0, `bcnt`=0.
- `data_o`, `keep_o`, `valid_o` and `last_o` are registered.
- The first header beat is valid 2 cycles after the descriptor handshake.
- With `ready_i` held high, throughput is one message data beat per cycle, plus one bubble cycle per message (LEN).
- While `valid_o & ~ready_i`, all outputs hold stable and both readies are low.
- A reset mid-packet takes effect the next cycle. The partial packet is abandoned with no `last_o`.
- `pkt_valid_i` outside IDLE is ignored.

## Test plan
- Heartbeat: sid bytes 01..0A, seq=1, cnt=0.
  - Beat 0: 0x0807060504030201.
  - Beat 1: seq bytes 00×6 in the upper lanes.
  - Beat 2: keep 0x0F, last, bytes {00,01,00,00}.
- One message, len 2, body AA BB: 3 beats. Beat 2 bytes are {00,01,00,01,00,02,AA,BB}, keep 0xFF, last.
- Two messages, len 7 then 9: total 40 bytes in 5 beats. Check the prefix for message 2 at byte offset 29 (beat 3 lane 5) and the last beat with keep 0xFF.
- The same stimulus with `ready_i` toggling 1/0 every cycle: identical beat sequence, and outputs are stable while stalled.
- One message, len 11: 33 bytes. Goes through FLUSH; final beat keep 0x01, last.
- Reset asserted during DATA of a 3-message packet: next cycle `valid_o`=0 and `pkt_ready_o`=1. The following heartbeat packet is bit-exact.
